bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). Sits between the PWM duty/frequency registers and the four-digit seven-segment driver, and produces its four 4-bit digit inputs. The in0..in3 contract is: in0 = rightmost/ones digit, codes 0-9 are numerals, all other codes show the driver's default pattern. Digit outputs are registered and update atomically, so the display never shows a partial conversion.

Parameters:
BIN_W, 14, width of binary input; 14 bits covers 0..9999 (max 16383).
DIGITS, 4, number of BCD digits produced; fixed at 4 to match the display.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-low reset (sampled on rising clock edge).
start  in  1  request conversion of bin_in; accepted only in IDLE.
bin_in  in  BIN_W  binary value, sampled on the accepted start cycle.
busy  out  1  high from cycle after accepted start until done cycle inclusive.
done  out  1  one-cycle pulse; digit outputs valid and updated on this cycle.
ovf  out  1  registered; set if last converted value > 9999.
bcd0  out  4  ones digit (drives in0).
bcd1  out  4  tens digit (drives in1).
bcd2  out  4  hundreds digit (drives in2).
bcd3  out  4  thousands digit (drives in3).

Behaviour:
- Reset (reset==0 at edge): state IDLE; busy=0, done=0, ovf=0, bcd0..bcd3=0, shift counter=0, internal scratch=0. Reset mid-conversion aborts; no done pulse.
- States: IDLE -> SHIFT -> FINISH -> IDLE.
- IDLE: on start=1, latch bin_in into shift reg, clear 16-bit BCD scratch, counter=0, go to SHIFT.
- SHIFT: each cycle, for each scratch nibble >=5 add 3, then shift {scratch,shift_reg} left 1. counter++; after BIN_W shifts go to FINISH.
- FINISH: ovf = (latched value > 9999); if ovf, bcd0..3 = 4'hA, else bcd0..3 = scratch nibbles. done=1 this cycle only; then IDLE.
- Latency: start accepted at edge T -> done high at cycle T+BIN_W+1 (15 for BIN_W=14). Back-to-back start is accepted the cycle after done.
- start while busy: ignored, not queued. bin_in changes while busy: no effect.
- Outputs hold their last value between conversions.
- Overflow check uses the latched input, compared at full BIN_W width.

Optional Feature:
Macro BIN2BCD_LEADING_BLANK_EN.
- Defined: in FINISH, when not ovf, leading zero digits among bcd3..bcd1 become 4'hF (blank); bcd0 is never blanked, so value 0 shows as F,F,F,0.
- Undefined: all digits output as computed, leading zeros shown.

Decomposition:
- Package bin2bcd_pkg: state encoding (IDLE, SHIFT, FINISH), BCD_OVF=4'hA, BCD_BLANK=4'hF, BCD_MAX=9999.
- Sub-module bcd_add3: combinational 4-bit nibble correction (>=5 -> +3), instantiated DIGITS times in SHIFT datapath.

Test Plan:
- Reset low 2 cycles, then start with bin_in=1234 -> done at cycle 15 after start; bcd3..0=1,2,3,4; ovf=0; busy high for exactly 15 cycles.
- bin_in=0 then 9999 back-to-back (second start on cycle after done) -> digits 0,0,0,0 then 9,9,9,9; ovf=0 both; 2 done pulses.
- bin_in=10000 -> bcd3..0=A,A,A,A, ovf=1; next conversion of 5 clears ovf, digits 0,0,0,5.
- Start=1 with bin_in=42 followed by start=1 with bin_in=7 at cycle 3 while busy -> single done at cycle 15, digits 0,0,4,2.
- Reset low at SHIFT cycle 6 of a 1234 conversion -> no done pulse; outputs 0, busy 0 the next cycle; fresh start converts correctly.
- With BIN2BCD_LEADING_BLANK_EN: 42 -> F,F,4,2; 0 -> F,F,F,0; 1005 -> 1,0,0,5.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared encodings and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0]  BCD_OVF   = 4'hA;
  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam int unsigned BCD_MAX   = 32'd9999;

  // Blank leading zero digits among the upper three; the ones digit always shows.
  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic [15:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (d[i*4 +: 4] == 4'd0)) begin
        r[i*4 +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble correction: digits of 5 or more get 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding a 4-digit display.
// Optional macro BIN2BCD_LEADING_BLANK_EN blanks leading zero digits (4'hF).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t                  state;
  logic [BIN_W-1:0]        shreg;
  logic [BIN_W-1:0]        bin_lat;
  logic [4*DIGITS-1:0]     scratch;
  logic [CNT_W-1:0]        cnt;

  logic [4*DIGITS-1:0]       corr;
  logic [4*DIGITS+BIN_W-1:0] cat;
  logic [4*DIGITS-1:0]       scr_next;
  logic [BIN_W-1:0]          sh_next;
  logic                      over;
  logic [4*DIGITS-1:0]       fin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[g*4 +: 4]),
      .dout (corr[g*4 +: 4])
    );
  end

  assign cat      = {corr, shreg} << 1;
  assign scr_next = cat[4*DIGITS+BIN_W-1 -: 4*DIGITS];
  assign sh_next  = cat[BIN_W-1:0];
  assign over     = (32'(bin_lat) > BCD_MAX);

  // Digit pattern presented on the last shift edge, using the final shifted scratch.
  always_comb begin
    fin = scr_next;
    if (over) begin
      fin = {DIGITS{BCD_OVF}};
    end else begin
`ifdef BIN2BCD_LEADING_BLANK_EN
      fin = blank_leading(scr_next);
`else
      fin = scr_next;
`endif
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bin_lat <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd0    <= 4'd0;
      bcd1    <= 4'd0;
      bcd2    <= 4'd0;
      bcd3    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin_in;
            bin_lat <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= sh_next;
          scratch <= scr_next;
          cnt     <= cnt + 1'b1;
          // Outputs update on the final shift edge so done and digits appear together.
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= FINISH;
            done  <= 1'b1;
            ovf   <= over;
            bcd0  <= fin[3:0];
            bcd1  <= fin[7:4];
            bcd2  <= fin[11:8];
            bcd3  <= fin[15:12];
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Table-driven bench with a scoreboard queue for bin2bcd_seq.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done, ovf;
  logic [3:0]       bcd0, bcd1, bcd2, bcd3;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut (
    .clock (clock), .reset (reset), .start (start), .bin_in (bin_in),
    .busy  (busy),  .done  (done),  .ovf   (ovf),
    .bcd0  (bcd0),  .bcd1  (bcd1),  .bcd2  (bcd2),  .bcd3  (bcd3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      dig;
    logic             ovf;
  } vec_t;

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts busy cycles and scores every done pulse against the queue.
  always @(negedge clock) begin
    if (busy === 1'b1) busy_cnt++;
    else busy_cnt = 0;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, mon_e.dig});
        check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
        check("latency", cyc + 1 - mon_e.acc, BIN_W + 1);
        check("busy_len", busy_cnt, BIN_W + 1);
      end
    end
  end

  function automatic logic [15:0] exp_dig(input logic [15:0] d, input logic o);
    logic [15:0] r;
    r = d;
`ifdef BIN2BCD_LEADING_BLANK_EN
    if (!o) begin
      if (r[15:12] == 4'd0) begin
        r[15:12] = 4'hF;
        if (r[11:8] == 4'd0) begin
          r[11:8] = 4'hF;
          if (r[7:4] == 4'd0) r[7:4] = 4'hF;
        end
      end
    end
`endif
    return r;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(busy === 1'b0 && done === 1'b0) && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Drive one conversion; optionally poke a second start while busy.
  task automatic run(input vec_t v, input int poke_at);
    exp_t x;
    int   k;
    wait_idle();
    start  = 1'b1;
    bin_in = v.bin;
    x.dig  = exp_dig(v.dig, v.ovf);
    x.ovf  = v.ovf;
    x.acc  = cyc + 1;
    sb.push_back(x);
    @(negedge clock);
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      if (k == poke_at) begin
        start  = 1'b1;
        bin_in = 14'd7;
      end else begin
        start  = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  vec_t tbl[10];
  vec_t v;
  int   d0;

  initial begin
    tbl[0] = '{14'd1234,  16'h1234, 1'b0};
    tbl[1] = '{14'd0,     16'h0000, 1'b0};
    tbl[2] = '{14'd9999,  16'h9999, 1'b0};
    tbl[3] = '{14'd10000, 16'hAAAA, 1'b1};
    tbl[4] = '{14'd5,     16'h0005, 1'b0};
    tbl[5] = '{14'd16383, 16'hAAAA, 1'b1};
    tbl[6] = '{14'd1005,  16'h1005, 1'b0};
    tbl[7] = '{14'd42,    16'h0042, 1'b0};
    tbl[8] = '{14'd9999,  16'h9999, 1'b0};
    tbl[9] = '{14'd1,     16'h0001, 1'b0};

    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run(tbl[i], -1);

    // Start while busy must be ignored: exactly one done for 42.
    d0 = done_cnt;
    v  = '{14'd42, 16'h0042, 1'b0};
    run(v, 2);
    repeat (20) @(negedge clock);
    check("busy_start_ignored", done_cnt - d0, 32'd1);

    // Reset during SHIFT aborts the conversion with no done pulse.
    wait_idle();
    d0     = done_cnt;
    start  = 1'b1;
    bin_in = 14'd1234;
    @(negedge clock);
    start  = 1'b0;
    repeat (6) @(negedge clock);
    reset  = 1'b0;
    @(negedge clock);
    reset  = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ovf",  {31'd0, ovf},  32'd0);
    check("abort_digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    repeat (20) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 32'd0);
    run(tbl[0], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
